tmr_fault_monitor: RTL and testbench
====================================

Name: tmr_fault_monitor

Overview:
Downstream consumer of the triple-modular-redundant (TMR) counter. It compares each replica count (q_1..q_3) against the voted count every enabled cycle and classifies each replica as healthy, suspect or failed. It also detects uncorrectable cycles, where no two replicas agree, and queues fault events in a small FIFO that a status/logging master drains with a valid/ready handshake.

Parameters:
WIDTH, 32, width of replica and voted counts
PERSIST, 3, consecutive mismatching enabled cycles that declare a replica FAILED (legal range 1..15)
CNT_W, 8, width of each per-replica saturating total-fault counter
FIFO_DEPTH, 4, event queue depth (power of two, at least 2)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
enable  in  1  monitoring qualifier, driven by the same enable as the counters
q_1  in  WIDTH  replica 1 count
q_2  in  WIDTH  replica 2 count
q_3  in  WIDTH  replica 3 count
voted_q  in  WIDTH  voter output
clear  in  1  synchronous clear of health state, counters and sticky flags
health_1  out  2  replica 1 state (health_t)
health_2  out  2  replica 2 state (health_t)
health_3  out  2  replica 3 state (health_t)
fault_cnt_1  out  CNT_W  replica 1 saturating mismatch count
fault_cnt_2  out  CNT_W  replica 2 saturating mismatch count
fault_cnt_3  out  CNT_W  replica 3 saturating mismatch count
failed_any  out  1  OR of (health_n == FAILED)
uncorr  out  1  sticky: an uncorrectable cycle occurred
overflow  out  1  sticky: an event was dropped
ev_valid  out  1  FIFO non-empty
ev_ready  in  1  consumer accepts the head event
ev_replica  out  2  head event replica: 0, 1, 2 = replica 1..3; 3 = all
ev_kind  out  2  head event kind (ev_kind_t)
ev_value  out  WIDTH  voted_q sampled in the event cycle

Behaviour:
- Reset (asynchronous): all health_n = HEALTHY, all fault_cnt_n = 0, run counters = 0, uncorr = 0, overflow = 0, FIFO empty, ev_valid = 0.
- Mismatch (combinational): mm_n = (q_n != voted_q).
- Uncorrectable cycle (combinational): unc = (q_1 != q_2) && (q_1 != q_3) && (q_2 != q_3).
- If any pair of replicas agrees, at most one mm_n is 1. This gives at most one event per cycle.
- Updates are taken only on posedge clk with enable = 1. With enable = 0, all state holds.
- clear = 1 has priority over monitoring: health returns to HEALTHY, fault_cnt and run counters go to 0, uncorr and overflow go to 0. The FIFO is not flushed and ev handshakes still occur.
- Uncorrectable cycle: uncorr is set and event {replica 3, UNCORR, voted_q} is pushed. Per-replica trackers hold for that cycle.
- Otherwise, per replica (registered; all outputs update one clk after the sampled cycle):
  - HEALTHY, mm: go to SUSPECT, run = 1, push TRANSIENT. If PERSIST == 1, go directly to FAILED and push FAILED instead.
  - HEALTHY, no mm: stay.
  - SUSPECT, mm: run++. If the new run == PERSIST, go to FAILED and push FAILED; otherwise stay, with no event.
  - SUSPECT, no mm: go to HEALTHY, run = 0, no event.
  - FAILED: sticky until clear or rst. No events are generated.
  - In every state, mm increments fault_cnt_n, saturating at 2^CNT_W-1. The counter never wraps.
- FIFO:
  - First-word fall-through; ev_* reflect the head entry while ev_valid = 1.
  - A pop occurs when ev_valid && ev_ready.
  - A push is accepted if occupancy < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - A push into a full FIFO with no pop is dropped and sets overflow. FIFO contents are unchanged.
  - A push into an empty FIFO makes ev_valid = 1 on the next cycle.
  - ev_ready while empty has no effect.
- failed_any is combinational from the registered health state.

Decomposition:
- Package tmr_mon_pkg:
  - health_t enum, 2 bits: HEALTHY = 0, SUSPECT = 1, FAILED = 2.
  - ev_kind_t enum, 2 bits: TRANSIENT = 0, FAILED = 1, UNCORR = 2.
  - REPLICA_ALL = 2'd3.
  - Parameterised event_t packing {replica, kind, value}.
- Sub-module replica_health_tracker, instantiated 3 times.
  - Inputs: clk, rst, enable, clear, mm, hold (= unc).
  - Outputs: health, fault_cnt, ev_transient, ev_failed.
- FIFO and event muxing are built in the top module.

Test Plan:
- Fault-free run: rst, then enable for 20 cycles with q_1 = q_2 = q_3 = voted_q counting 0..19 -> all health HEALTHY, all fault_cnt 0, ev_valid stays 0.
- Transient fault: q_2 = 0x55 for one cycle while q_1 = q_3 = voted_q = 0x10 -> health_2 = SUSPECT for one cycle then back to HEALTHY, fault_cnt_2 = 1, one event {1, TRANSIENT, 0x10}.
- Persistent fault: q_3 mismatches for 3 consecutive enabled cycles (PERSIST = 3) -> health_3 = FAILED after the 3rd cycle, failed_any = 1, events TRANSIENT then FAILED. clear -> HEALTHY, fault_cnt_3 = 0.
- Uncorrectable: q_1 = 1, q_2 = 2, q_3 = 4 -> uncorr = 1, event {3, UNCORR, voted_q}, all health unchanged.
- Overflow with back-pressure: ev_ready = 0, five transient events on alternating replicas -> four queued, overflow = 1. Then ev_ready = 1 -> four events drain in order and ev_valid drops. Push plus pop while full is accepted.
- Saturation and reset: CNT_W = 4, replica 1 mismatches for 20 cycles -> fault_cnt_1 holds at 15. Assert rst mid-stream -> all outputs return to reset values immediately, before the next clk edge.

Source files
------------

// File: rtl/tmr_fault_monitor_pkg.sv
// Shared types for the TMR fault monitor: replica health states, event kinds
// and the event header carried through the event queue.
package tmr_mon_pkg;

  typedef enum logic [1:0] {
    HEALTHY = 2'd0,
    SUSPECT = 2'd1,
    FAILED  = 2'd2
  } health_t;

  // Event kinds carry an EV_ prefix so they can share scope with health_t.
  typedef enum logic [1:0] {
    EV_TRANSIENT = 2'd0,
    EV_FAILED    = 2'd1,
    EV_UNCORR    = 2'd2
  } ev_kind_t;

  localparam logic [1:0] REPLICA_ALL = 2'd3;

  // Run counter is wide enough for the largest legal persistence threshold (15).
  localparam int RUN_W = 4;

  typedef struct packed {
    logic [1:0] replica;
    ev_kind_t   kind;
  } ev_hdr_t;

  function automatic logic [1:0] replica_code(input int idx);
    return 2'(idx);
  endfunction

endpackage

// File: rtl/tmr_fault_monitor_replica_health_tracker.sv
// Per-replica health classifier: HEALTHY/SUSPECT/FAILED state machine with a
// consecutive-mismatch run counter and a saturating total-mismatch counter.
module replica_health_tracker
  import tmr_mon_pkg::*;
#(
  parameter int PERSIST = 3,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic             mm,
  input  logic             hold,
  output health_t          health,
  output logic [CNT_W-1:0] fault_cnt,
  output logic             ev_transient,
  output logic             ev_failed
);

  localparam logic [RUN_W-1:0] PERSIST_V = RUN_W'(PERSIST);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  health_t          r_health;
  logic [RUN_W-1:0] r_run;
  logic [CNT_W-1:0] r_cnt;

  health_t          w_health_nxt;
  logic [RUN_W-1:0] w_run_nxt;
  logic [RUN_W-1:0] w_run_inc;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_active;

  assign w_active  = enable && !clear && !hold;
  assign w_run_inc = r_run + 1'b1;

  always_comb begin
    w_health_nxt = r_health;
    w_run_nxt    = r_run;
    w_cnt_nxt    = r_cnt;
    ev_transient = 1'b0;
    ev_failed    = 1'b0;
    if (clear) begin
      w_health_nxt = HEALTHY;
      w_run_nxt    = '0;
      w_cnt_nxt    = '0;
    end else if (w_active && mm) begin
      if (r_cnt != CNT_MAX) w_cnt_nxt = r_cnt + 1'b1;
      case (r_health)
        HEALTHY: begin
          w_run_nxt = RUN_W'(1);
          if (PERSIST == 1) begin
            w_health_nxt = FAILED;
            ev_failed    = 1'b1;
          end else begin
            w_health_nxt = SUSPECT;
            ev_transient = 1'b1;
          end
        end
        SUSPECT: begin
          w_run_nxt = w_run_inc;
          if (w_run_inc == PERSIST_V) begin
            w_health_nxt = FAILED;
            ev_failed    = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (w_active && r_health == SUSPECT) begin
      // A single clean cycle clears a suspicion.
      w_health_nxt = HEALTHY;
      w_run_nxt    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_health <= HEALTHY;
      r_run    <= '0;
      r_cnt    <= '0;
    end else begin
      r_health <= w_health_nxt;
      r_run    <= w_run_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign health    = r_health;
  assign fault_cnt = r_cnt;

endmodule

// File: rtl/tmr_fault_monitor.sv
// TMR fault monitor: classifies each replica against the voted count, flags
// uncorrectable cycles and queues fault events in a first-word-fall-through FIFO.
module tmr_fault_monitor
  import tmr_mon_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int PERSIST    = 3,
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] q_1,
  input  logic [WIDTH-1:0] q_2,
  input  logic [WIDTH-1:0] q_3,
  input  logic [WIDTH-1:0] voted_q,
  input  logic             clear,
  output logic [1:0]       health_1,
  output logic [1:0]       health_2,
  output logic [1:0]       health_3,
  output logic [CNT_W-1:0] fault_cnt_1,
  output logic [CNT_W-1:0] fault_cnt_2,
  output logic [CNT_W-1:0] fault_cnt_3,
  output logic             failed_any,
  output logic             uncorr,
  output logic             overflow,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [1:0]       ev_replica,
  output logic [1:0]       ev_kind,
  output logic [WIDTH-1:0] ev_value
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    ev_hdr_t          hdr;
    logic [WIDTH-1:0] value;
  } event_t;

  logic [WIDTH-1:0] w_q [3];
  health_t          w_health [3];
  logic [CNT_W-1:0] w_cnt [3];
  logic [2:0]       w_mm;
  logic [2:0]       w_ev_tr;
  logic [2:0]       w_ev_fl;
  logic             w_unc;

  assign w_q[0] = q_1;
  assign w_q[1] = q_2;
  assign w_q[2] = q_3;
  assign w_unc  = (q_1 != q_2) && (q_1 != q_3) && (q_2 != q_3);

  for (genvar g = 0; g < 3; g++) begin : g_trk
    assign w_mm[g] = (w_q[g] != voted_q);
    replica_health_tracker #(
      .PERSIST (PERSIST),
      .CNT_W   (CNT_W)
    ) u_trk (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .clear        (clear),
      .mm           (w_mm[g]),
      .hold         (w_unc),
      .health       (w_health[g]),
      .fault_cnt    (w_cnt[g]),
      .ev_transient (w_ev_tr[g]),
      .ev_failed    (w_ev_fl[g])
    );
  end

  assign health_1    = w_health[0];
  assign health_2    = w_health[1];
  assign health_3    = w_health[2];
  assign fault_cnt_1 = w_cnt[0];
  assign fault_cnt_2 = w_cnt[1];
  assign fault_cnt_3 = w_cnt[2];
  assign failed_any  = (w_health[0] == FAILED) || (w_health[1] == FAILED) ||
                       (w_health[2] == FAILED);

  // Event selection: at most one source fires per cycle when a pair agrees.
  logic   w_push;
  event_t w_ev;

  always_comb begin
    w_push          = 1'b0;
    w_ev.hdr.replica = 2'd0;
    w_ev.hdr.kind    = EV_TRANSIENT;
    w_ev.value       = voted_q;
    if (enable && !clear && w_unc) begin
      w_push           = 1'b1;
      w_ev.hdr.replica = REPLICA_ALL;
      w_ev.hdr.kind    = EV_UNCORR;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_ev_tr[i] || w_ev_fl[i]) begin
          w_push           = 1'b1;
          w_ev.hdr.replica = replica_code(i);
          w_ev.hdr.kind    = w_ev_fl[i] ? EV_FAILED : EV_TRANSIENT;
        end
      end
    end
  end

  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [AW:0]   r_count;
  logic          r_uncorr;
  logic          r_overflow;
  event_t        r_mem [FIFO_DEPTH];

  logic   w_pop;
  logic   w_push_ok;
  logic   w_drop;
  event_t w_head;

  assign w_pop     = (r_count != '0) && ev_ready;
  assign w_push_ok = w_push && ((r_count != FULL_CNT) || w_pop);
  assign w_drop    = w_push && !w_push_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd       <= '0;
      r_wr       <= '0;
      r_count    <= '0;
      r_uncorr   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + 1'b1;
      if (w_pop)     r_rd <= r_rd + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (clear)                  r_uncorr <= 1'b0;
      else if (enable && w_unc)   r_uncorr <= 1'b1;
      if (clear)       r_overflow <= 1'b0;
      else if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Queue storage is pure data; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr] <= w_ev;
  end

  assign w_head     = r_mem[r_rd];
  assign ev_valid   = (r_count != '0);
  assign ev_replica = w_head.hdr.replica;
  assign ev_kind    = w_head.hdr.kind;
  assign ev_value   = w_head.value;
  assign uncorr     = r_uncorr;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// Directed plus randomized bench for tmr_fault_monitor with an event-queue
// reference model built from the replica classification rules.
module tb_tmr_fault_monitor;

  localparam int WIDTH   = 32;
  localparam int PERSIST = 3;
  localparam int CNT_W   = 4;
  localparam int DEPTH   = 4;
  localparam int CNT_MAX = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             clear;
  logic             ev_ready;
  logic [WIDTH-1:0] qv [3];
  logic [WIDTH-1:0] vq;
  logic [1:0]       health_1, health_2, health_3;
  logic [CNT_W-1:0] fault_cnt_1, fault_cnt_2, fault_cnt_3;
  logic             failed_any, uncorr, overflow, ev_valid;
  logic [1:0]       ev_replica, ev_kind;
  logic [WIDTH-1:0] ev_value;

  tmr_fault_monitor #(
    .WIDTH(WIDTH), .PERSIST(PERSIST), .CNT_W(CNT_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .q_1(qv[0]), .q_2(qv[1]), .q_3(qv[2]), .voted_q(vq), .clear(clear),
    .health_1(health_1), .health_2(health_2), .health_3(health_3),
    .fault_cnt_1(fault_cnt_1), .fault_cnt_2(fault_cnt_2), .fault_cnt_3(fault_cnt_3),
    .failed_any(failed_any), .uncorr(uncorr), .overflow(overflow),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_replica(ev_replica),
    .ev_kind(ev_kind), .ev_value(ev_value)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: runs, totals and failure flags per replica, plus an event list.
  typedef struct {
    int               rep;
    int               kind;
    logic [WIDTH-1:0] val;
  } mev_t;

  int   m_cnt [3];
  int   m_run [3];
  bit   m_failed [3];
  bit   m_uncorr;
  bit   m_ovf;
  mev_t m_q [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_run[i] = 0; m_failed[i] = 0;
    end
    m_uncorr = 0;
    m_ovf    = 0;
    m_q.delete();
  endtask

  task automatic model_step();
    bit   pop  = (m_q.size() > 0) && ev_ready;
    int   sz   = m_q.size();
    bit   push = 0;
    mev_t e;
    if (clear) begin
      for (int i = 0; i < 3; i++) begin
        m_cnt[i] = 0; m_run[i] = 0; m_failed[i] = 0;
      end
      m_uncorr = 0;
      m_ovf    = 0;
    end else if (enable) begin
      if (qv[0] != qv[1] && qv[0] != qv[2] && qv[1] != qv[2]) begin
        m_uncorr = 1;
        push = 1;
        e = '{3, 2, vq};
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (qv[i] != vq) begin
            if (m_cnt[i] < CNT_MAX) m_cnt[i]++;
            if (!m_failed[i]) begin
              m_run[i]++;
              if (m_run[i] == PERSIST) begin
                m_failed[i] = 1;
                push = 1;
                e = '{i, 1, vq};
              end else if (m_run[i] == 1) begin
                push = 1;
                e = '{i, 0, vq};
              end
            end
          end else if (!m_failed[i]) begin
            m_run[i] = 0;
          end
        end
      end
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (sz < DEPTH || pop) m_q.push_back(e);
      else m_ovf = 1;
    end
  endtask

  function automatic int m_health(input int i);
    if (m_failed[i]) return 2;
    if (m_run[i] > 0) return 1;
    return 0;
  endfunction

  task automatic check_all();
    logic [1:0]       hh [3];
    logic [CNT_W-1:0] cc [3];
    hh[0] = health_1;    hh[1] = health_2;    hh[2] = health_3;
    cc[0] = fault_cnt_1; cc[1] = fault_cnt_2; cc[2] = fault_cnt_3;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("health_%0d", i + 1), 64'(hh[i]), 64'(m_health(i)));
      chk($sformatf("fault_cnt_%0d", i + 1), 64'(cc[i]), 64'(m_cnt[i]));
    end
    chk("failed_any", 64'(failed_any), 64'(m_failed[0] | m_failed[1] | m_failed[2]));
    chk("uncorr", 64'(uncorr), 64'(m_uncorr));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("ev_valid", 64'(ev_valid), 64'(m_q.size() > 0));
    if (m_q.size() > 0 && ev_valid) begin
      chk("ev_replica", 64'(ev_replica), 64'(m_q[0].rep));
      chk("ev_kind", 64'(ev_kind), 64'(m_q[0].kind));
      chk("ev_value", 64'(ev_value), 64'(m_q[0].val));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic set_all(input logic [WIDTH-1:0] v);
    qv[0] = v; qv[1] = v; qv[2] = v; vq = v;
  endtask

  task automatic drain(input int n);
    ev_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
    ev_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; clear = 1'b0; ev_ready = 1'b0;
    set_all('0);
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Fault-free counting run
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_all(WIDTH'(i));
      step();
    end
    chk("clean_ev_valid", 64'(ev_valid), 64'(0));

    // Single-cycle transient on replica 2
    set_all(32'h10);
    qv[1] = 32'h55;
    step();
    chk("tr_health_2", 64'(health_2), 64'(1));
    chk("tr_cnt_2", 64'(fault_cnt_2), 64'(1));
    chk("tr_ev_rep", 64'(ev_replica), 64'(1));
    chk("tr_ev_kind", 64'(ev_kind), 64'(0));
    chk("tr_ev_val", 64'(ev_value), 64'(32'h10));
    qv[1] = 32'h10;
    step();
    chk("tr_health_2_back", 64'(health_2), 64'(0));
    drain(2);

    // Persistent fault on replica 3, then clear
    for (int i = 0; i < 3; i++) begin
      set_all(WIDTH'(32'h100 + i));
      qv[2] = 32'hdead0000 + WIDTH'(i);
      step();
    end
    chk("pf_health_3", 64'(health_3), 64'(2));
    chk("pf_failed_any", 64'(failed_any), 64'(1));
    chk("pf_ev_kind_first", 64'(ev_kind), 64'(0));
    set_all(32'h200);
    clear = 1'b1;
    ev_ready = 1'b1;
    step();
    clear = 1'b0;
    ev_ready = 1'b0;
    chk("clr_health_3", 64'(health_3), 64'(0));
    chk("clr_cnt_3", 64'(fault_cnt_3), 64'(0));
    drain(3);

    // Uncorrectable cycle
    qv[0] = 32'd1; qv[1] = 32'd2; qv[2] = 32'd4; vq = 32'd1;
    step();
    chk("unc_flag", 64'(uncorr), 64'(1));
    chk("unc_ev_rep", 64'(ev_replica), 64'(3));
    chk("unc_ev_kind", 64'(ev_kind), 64'(2));
    set_all(32'h300);
    drain(2);

    // Overflow under back-pressure, then push+pop while full
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_all(WIDTH'(32'h400 + k));
      qv[k % 2] = ~vq;
      step();
    end
    chk("ovf_flag", 64'(overflow), 64'(1));
    set_all(32'h500);
    qv[2] = 32'h501;
    ev_ready = 1'b1;
    step();
    set_all(32'h600);
    drain(5);
    chk("ovf_drained", 64'(ev_valid), 64'(0));

    // Saturation of replica 1's total counter, then asynchronous reset
    clear = 1'b1;
    step();
    clear = 1'b0;
    ev_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_all(WIDTH'(32'h700 + i));
      qv[0] = 32'hffff0000 ^ WIDTH'(i);
      step();
    end
    chk("sat_cnt_1", 64'(fault_cnt_1), 64'(15));
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_cnt_1", 64'(fault_cnt_1), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [WIDTH-1:0] v;
      int r;
      int k;
      v = $urandom;
      r = $urandom_range(0, 9);
      set_all(v);
      if (r >= 6 && r <= 8) begin
        k = $urandom_range(0, 2);
        qv[k] = v ^ (WIDTH'($urandom_range(1, 255)));
      end else if (r == 9) begin
        qv[1] = v + 1;
        qv[2] = v + 2;
        vq = $urandom;
      end
      enable   = ($urandom_range(0, 9) != 0);
      clear    = ($urandom_range(0, 39) == 0);
      ev_ready = $urandom_range(0, 1) == 1;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
